// File: rtl/bus_mover.sv
// bus_mover: queues {src,dst} move commands and executes each one as a single
// source-drive cycle followed by a single destination-load cycle.
module bus_mover #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  input  logic [WIDTH-1:0] bus_data,
  output logic [3:0]       drive_en,
  output logic [3:0]       load_en,
  output logic [WIDTH-1:0] load_data,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             ready_r;
  logic [1:0]       dst_r;
  logic [WIDTH-1:0] hold_r;
  logic [3:0]       drive_r;
  logic [3:0]       load_r;
  logic             busy_r;
  logic             done_r;
  logic             push_s;
  logic             pop_s;
  logic             nonempty_s;
  logic [3:0]       head_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // FIFO handshake decode and next occupancy
  always_comb begin
    nonempty_s   = (count_r != {CW{1'b0}});
    push_s       = cmd_valid && ready_r;
    head_s       = mem_r[rd_ptr_r];
    pop_s        = 1'b0;
    count_next_s = count_r;
    case (state_r)
      IDLE, LOAD: pop_s = nonempty_s;
      default:    pop_s = 1'b0;
    endcase
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1'b1);
      2'b01:   count_next_s = count_r - CW'(1'b1);
      default: count_next_s = count_r;
    endcase
  end

  // Command storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= {cmd_src, cmd_dst};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_next_s;
      // a slot freed by a pop only shows up as ready after the edge
      ready_r <= (count_next_s < CW'(DEPTH));
    end
  end

  // Move sequencer with registered enables, data, busy and done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      dst_r   <= 2'b00;
      hold_r  <= {WIDTH{1'b0}};
      drive_r <= 4'b0000;
      load_r  <= 4'b0000;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, LOAD: begin
          load_r <= 4'b0000;
          done_r <= 1'b0;
          if (nonempty_s) begin
            state_r <= DRIVE;
            dst_r   <= head_s[1:0];
            drive_r <= onehot(head_s[3:2]);
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            drive_r <= 4'b0000;
            busy_r  <= (count_next_s != {CW{1'b0}});
          end
        end
        DRIVE: begin
          state_r <= LOAD;
          hold_r  <= bus_data;
          drive_r <= 4'b0000;
          load_r  <= onehot(dst_r);
          done_r  <= 1'b1;
          busy_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          drive_r <= 4'b0000;
          load_r  <= 4'b0000;
          done_r  <= 1'b0;
          busy_r  <= (count_next_s != {CW{1'b0}});
        end
      endcase
    end
  end

  assign cmd_ready = ready_r;
  assign drive_en  = drive_r;
  assign load_en   = load_r;
  assign load_data = hold_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_bus_mover.sv
// Self-checking bench for bus_mover: directed scenarios plus a randomized run
// checked against a move-timing model built from the arithmetic scheduling rules.
module tb_bus_mover;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_src;
  logic [1:0]       cmd_dst;
  logic [WIDTH-1:0] bus_data;
  logic [3:0]       drive_en;
  logic [3:0]       load_en;
  logic [WIDTH-1:0] load_data;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  bus_mover #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .bus_data(bus_data),
    .drive_en(drive_en), .load_en(load_en), .load_data(load_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // drive inputs mid-cycle, then return just after the next rising edge
  task automatic cyc(input logic v, input logic [1:0] s, input logic [1:0] d, input logic [7:0] b);
    @(negedge clk);
    cmd_valid = v;
    cmd_src   = s;
    cmd_dst   = d;
    bus_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cyc(1'b0, 2'd0, 2'd0, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b1, 2'd2, 2'd3, 8'hFF);
    cyc(1'b1, 2'd1, 2'd0, 8'hEE);
    n_checks++; if (drive_en !== 4'b0000) begin n_fail++; $display("FAIL reset_drive got %b want 0000", drive_en); end
    n_checks++; if (load_en !== 4'b0000) begin n_fail++; $display("FAIL reset_load got %b want 0000", load_en); end
    n_checks++; if (load_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", load_data); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'd0, 2'd0, 8'h00);
      n_checks++; if (busy !== 1'b0 || drive_en !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ignored_cmd cycle %0d got busy=%b drive=%b want 0/0000", i, busy, drive_en);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    cyc(1'b1, 2'd0, 2'd1, 8'h00);
    n_checks++; if (drive_en !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_accept got drive=%b busy=%b want 0000/1", drive_en, busy);
    end
    cyc(1'b0, 2'd0, 2'd0, 8'h00);
    n_checks++; if (drive_en !== 4'b0001) begin n_fail++; $display("FAIL single_drive got %b want 0001", drive_en); end
    n_checks++; if (load_en !== 4'b0000) begin n_fail++; $display("FAIL single_noload got %b want 0000", load_en); end
    cyc(1'b0, 2'd0, 2'd0, 8'hA1);
    n_checks++; if (load_en !== 4'b0010) begin n_fail++; $display("FAIL single_load got %b want 0010", load_en); end
    n_checks++; if (load_data !== 8'hA1) begin n_fail++; $display("FAIL single_data got %h want a1", load_data); end
    n_checks++; if (done !== 1'b1 || drive_en !== 4'b0000) begin
      n_fail++; $display("FAIL single_done got done=%b drive=%b want 1/0000", done, drive_en);
    end
    cyc(1'b0, 2'd0, 2'd0, 8'h3C);
    n_checks++; if (done !== 1'b0 || load_en !== 4'b0000) begin
      n_fail++; $display("FAIL single_after got done=%b load=%b want 0/0000", done, load_en);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", busy); end
    n_checks++; if (load_data !== 8'hA1) begin n_fail++; $display("FAIL single_hold got %h want a1", load_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_drv;
    logic [3:0] exp_ld;
    apply_reset();
    for (int off = 0; off < 8; off++) begin
      cyc(off < 3, 2'(off), 2'(off + 1), 8'(8'h30 + off));
      exp_drv = ((off % 2) == 1 && off <= 5) ? 4'(4'b0001 << ((off - 1) / 2)) : 4'b0000;
      exp_ld  = ((off % 2) == 0 && off >= 2 && off <= 6) ? 4'(4'b0001 << (off / 2)) : 4'b0000;
      n_checks++; if (drive_en !== exp_drv) begin n_fail++; $display("FAIL b2b_drive off %0d got %b want %b", off, drive_en, exp_drv); end
      n_checks++; if (load_en !== exp_ld) begin n_fail++; $display("FAIL b2b_load off %0d got %b want %b", off, load_en, exp_ld); end
      n_checks++; if (done !== (exp_ld != 4'b0000)) begin n_fail++; $display("FAIL b2b_done off %0d got %b want %b", off, done, exp_ld != 4'b0000); end
      n_checks++; if (busy !== (off <= 6)) begin n_fail++; $display("FAIL b2b_busy off %0d got %b want %b", off, busy, off <= 6); end
      if (exp_ld != 4'b0000) begin
        n_checks++; if (load_data !== 8'(8'h30 + off)) begin n_fail++; $display("FAIL b2b_data off %0d got %h want %h", off, load_data, 8'(8'h30 + off)); end
      end
    end
  endtask

  // valid held high: moves run back to back, pops land on every odd edge
  task automatic test_full();
    int k;
    int occ;
    bit rdy_prev;
    bit exp_rdy;
    logic [7:0] b;
    logic [3:0] exp_drv;
    logic [3:0] exp_ld;
    apply_reset();
    k = 0;
    rdy_prev = 1'b1;
    for (int e = 0; e < 14; e++) begin
      b = 8'($urandom);
      cyc(1'b1, 2'(k % 4), 2'((k + 2) % 4), b);
      if (rdy_prev) k++;
      occ = k - (e + 1) / 2;
      exp_rdy = (occ < DEPTH);
      rdy_prev = exp_rdy;
      exp_drv = ((e % 2) == 1) ? 4'(4'b0001 << (((e - 1) / 2) % 4)) : 4'b0000;
      exp_ld  = ((e % 2) == 0 && e >= 2) ? 4'(4'b0001 << ((((e - 2) / 2) + 2) % 4)) : 4'b0000;
      n_checks++; if (cmd_ready !== exp_rdy) begin n_fail++; $display("FAIL full_ready edge %0d got %b want %b", e, cmd_ready, exp_rdy); end
      n_checks++; if (drive_en !== exp_drv) begin n_fail++; $display("FAIL full_drive edge %0d got %b want %b", e, drive_en, exp_drv); end
      n_checks++; if (load_en !== exp_ld) begin n_fail++; $display("FAIL full_load edge %0d got %b want %b", e, load_en, exp_ld); end
      if (exp_ld != 4'b0000) begin
        n_checks++; if (load_data !== b) begin n_fail++; $display("FAIL full_data edge %0d got %h want %h", e, load_data, b); end
      end
    end
  endtask

  task automatic test_self();
    apply_reset();
    cyc(1'b1, 2'd2, 2'd2, 8'h00);
    cyc(1'b0, 2'd0, 2'd0, 8'h00);
    n_checks++; if (drive_en !== 4'b0100) begin n_fail++; $display("FAIL self_drive got %b want 0100", drive_en); end
    cyc(1'b0, 2'd0, 2'd0, 8'h5C);
    n_checks++; if (load_en !== 4'b0100) begin n_fail++; $display("FAIL self_load got %b want 0100", load_en); end
    n_checks++; if (load_data !== 8'h5C) begin n_fail++; $display("FAIL self_data got %h want 5c", load_data); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'(i), 2'(3 - i), 8'($urandom));
    end
    n_checks++; if (drive_en !== 4'b0010) begin n_fail++; $display("FAIL mid_drive got %b want 0010", drive_en); end
    rst_n = 1'b0;
    cyc(1'b1, 2'd0, 2'd0, 8'h77);
    n_checks++; if (drive_en !== 4'b0000 || load_en !== 4'b0000 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_outputs got drive=%b load=%b done=%b want 0000/0000/0", drive_en, load_en, done);
    end
    n_checks++; if (load_data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h want 00", load_data); end
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_status got busy=%b ready=%b want 0/1", busy, cmd_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 2'd0, 2'd0, 8'h00);
      n_checks++; if (load_en !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_aborted cycle %0d got load=%b done=%b busy=%b want 0000/0/0", i, load_en, done, busy);
      end
    end
  endtask

  typedef struct {
    logic [1:0] s;
    logic [1:0] d;
    int         de;
  } mv_t;

  // each move drives at max(accept+1, previous drive+2) and loads one edge later
  task automatic test_random();
    mv_t        q[$];
    mv_t        m;
    int         last_de;
    int         occ;
    bit         mready;
    logic       v;
    logic [1:0] s;
    logic [1:0] d;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic [3:0] exp_drv;
    logic [3:0] exp_ld;
    logic       exp_done;
    logic       exp_busy;
    apply_reset();
    last_de  = -100;
    mready   = 1'b1;
    exp_data = 8'h00;
    for (int e = 0; e < 400; e++) begin
      v = ($urandom_range(0, 99) < (((e / 100) % 2 == 1) ? 85 : 30));
      s = 2'($urandom_range(0, 3));
      d = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      cyc(v, s, d, b);
      if (v && mready) begin
        m.s  = s;
        m.d  = d;
        m.de = (e + 1 > last_de + 2) ? e + 1 : last_de + 2;
        last_de = m.de;
        q.push_back(m);
      end
      exp_drv  = 4'b0000;
      exp_ld   = 4'b0000;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      occ      = 0;
      foreach (q[i]) begin
        if (q[i].de == e) exp_drv = 4'b0001 << q[i].s;
        if (q[i].de + 1 == e) begin
          exp_ld   = 4'b0001 << q[i].d;
          exp_done = 1'b1;
          exp_data = b;
        end
        if (q[i].de > e) occ++;
        else exp_busy = 1'b1;
      end
      if (occ != 0) exp_busy = 1'b1;
      while (q.size() > 0 && q[0].de + 1 <= e) void'(q.pop_front());
      mready = (occ < DEPTH);
      n_checks++; if (drive_en !== exp_drv) begin n_fail++; $display("FAIL rnd_drive edge %0d got %b want %b", e, drive_en, exp_drv); end
      n_checks++; if (load_en !== exp_ld) begin n_fail++; $display("FAIL rnd_load edge %0d got %b want %b", e, load_en, exp_ld); end
      n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL rnd_done edge %0d got %b want %b", e, done, exp_done); end
      n_checks++; if (load_data !== exp_data) begin n_fail++; $display("FAIL rnd_data edge %0d got %h want %h", e, load_data, exp_data); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy edge %0d got %b want %b", e, busy, exp_busy); end
      n_checks++; if (cmd_ready !== mready) begin n_fail++; $display("FAIL rnd_ready edge %0d got %b want %b", e, cmd_ready, mready); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = 2'd0;
    cmd_dst   = 2'd0;
    bus_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_self();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
